sd_block_responder: RTL and testbench
=====================================

SD_BLOCK_RESPONDER -- requirements
Module: sd_block_responder

Interface
REQ-001 Parameter VDNUM, default 2, number of virtual drives served.
REQ-002 Parameter AW, default 24, backing-store byte address width; address = {drive, lba, offset[8:0]}, truncated/zero-extended to AW.
REQ-003 Port clk_sys  in  1  system clock; one clock only; reset is synchronous and active-low.
REQ-004 Port reset_n  in  1  synchronous active-low reset.
REQ-005 Port sd_lba  in  VDNUM x 32  block number per drive.
REQ-006 Port sd_rd / sd_wr  in  VDNUM each  level read/write requests per drive.
REQ-007 Port sd_ack  out  VDNUM  per-drive transfer acknowledge; at most one bit high.
REQ-008 Port sd_buff_addr  out  9  byte offset in current 512-byte block.
REQ-009 Port sd_buff_dout  out  8  read data to initiator; sd_buff_wr  out  1  one-cycle strobe.
REQ-010 Port sd_buff_din  in  VDNUM x 8  write data from initiator buffer, valid one cycle after sd_buff_addr.
REQ-011 Port img_blocks  in  VDNUM x 32  image size in blocks; 0 = not mounted.
REQ-012 Port mem_addr out AW; mem_rd, mem_wr out 1; mem_din out 8; mem_dout in 8; mem_ready in 1 (completes the outstanding access).
REQ-013 Port busy  out  1 (state != IDLE); err  out  1 (one-cycle pulse per rejected/out-of-range block).

Function
REQ-014 States: IDLE, ACK, RD_MEM, RD_PUT, WR_ADDR, WR_CAP, WR_MEM, DONE, GAP.
REQ-015 IDLE: drives with sd_rd or sd_wr high are candidates; round-robin starting at (last served + 1) mod VDNUM.
REQ-016 Same drive with both sd_rd and sd_wr high: read served first.
REQ-017 On grant: latch drive index, direction, sd_lba[n]; offset := 0; next state ACK.
REQ-018 ACK: raise sd_ack[n] (one cycle after grant), held until DONE; lba never resampled while acked.
REQ-019 Latched lba >= img_blocks[n]: no mem access; reads return 0x00 for all 512 bytes; writes discarded; err pulses once at grant.
REQ-020 Read: RD_MEM asserts mem_rd level with mem_addr until mem_ready; RD_PUT drives sd_buff_addr=offset, sd_buff_dout=captured mem_dout, sd_buff_wr=1 for exactly one cycle.
REQ-021 mem_ready already high in the cycle mem_rd rises completes that access (zero-wait store allowed).
REQ-022 Write: WR_ADDR drives sd_buff_addr=offset; WR_CAP captures sd_buff_din[n] next cycle; WR_MEM holds mem_wr, mem_addr, mem_din until mem_ready.
REQ-023 Offset increments after each byte; after offset 511 go DONE; no wrap within a block.
REQ-024 DONE: drop sd_ack; enter GAP for 2 cycles (ack low) before IDLE, letting initiator update lba/requests.
REQ-025 Request still high after GAP starts a new block transfer with freshly sampled lba (multi-block streaming).
REQ-026 Request deasserted mid-transfer: ignored; block completes.
REQ-027 sd_buff_wr low and sd_buff_addr held outside RD_PUT; mem_rd and mem_wr never high together.
REQ-028 Minimum read-block time with zero-wait store: 2 + 2x512 + 3 cycles.

Reset
REQ-029 reset_n low at a clock edge: state IDLE, sd_ack=0, sd_buff_wr=0, sd_buff_addr=0, sd_buff_dout=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_din=0, err=0, busy=0, round-robin pointer=last drive (drive 0 first).
REQ-030 Reset mid-transfer abandons the block in the cycle reset is sampled; outstanding mem_ready after reset ignored.

Configuration
REQ-031 Macro SD_BLOCK_WRITE_EN defined: write path per REQ-022.
REQ-032 Undefined: sd_wr-only requests still granted and acked for 512 cycles with no mem_wr and no buffer reads; err pulses at grant; WR_CAP/WR_MEM logic absent.

Structure
REQ-033 Package sd_block_pkg: state enum, BLK_BYTES=512, OFS_W=9.
REQ-034 Sub-module sd_rr_arbiter (VDNUM-wide round-robin grant with last-served pointer); remainder flat.

Verification
REQ-035 Drive0 read lba 5, img_blocks 100, zero-wait store with byte=addr[7:0] -> ack rises 1 cycle after grant, 512 strobes, addr 0..511, data 0x00..0xFF x2, ack low.
REQ-036 sd_rd[0] and sd_rd[1] high simultaneously after reset -> drive0 served, then drive1, then drive0.
REQ-037 Initiator holds sd_rd, lba++ on ack rise, for 13 blocks -> 13 transfers, lba n..n+12, 2-cycle ack-low gaps.
REQ-038 Write drive1 lba 3 with SD_BLOCK_WRITE_EN, store 3-cycle wait -> 512 mem_wr at {1,3,ofs} carrying buffer data; rebuilt without macro -> no mem_wr, err pulse.
REQ-039 Read lba 200, img_blocks 100 -> 512 bytes of 0x00, no mem_rd, one err pulse.
REQ-040 reset_n low at offset 300 -> next cycle ack=0, mem_rd=0, busy=0; next request starts at offset 0.

Source files
------------

// File: rtl/sd_block_pkg.sv
// Shared types and constants for the SD block responder.
package sd_block_pkg;

    localparam int BLK_BYTES = 512;
    localparam int OFS_W     = 9;

    typedef enum logic [3:0] {
        IDLE,
        ACK,
        RD_MEM,
        RD_PUT,
        WR_ADDR,
        WR_CAP,
        WR_MEM,
        DONE,
        GAP
    } state_e;

endpackage

// File: rtl/sd_rr_arbiter.sv
// Round-robin grant across N request lines. The search starts one past the
// last served index; the pointer only moves when the grant is taken.
module sd_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic [N-1:0]  req_i,
    input  logic          take_i,
    output logic          any_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] last_q;
    logic [IW-1:0] cand;

    // First requester found walking forward from last_q + 1.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last_q) + k) % N);
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

    // Last-served pointer; resets to the top drive so drive 0 wins first.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            last_q <= IW'(N - 1);
        end else if (take_i && any_o) begin
            last_q <= idx_o;
        end
    end

endmodule

// File: rtl/sd_block_responder.sv
// Serves 512-byte block reads/writes for VDNUM virtual drives from a byte
// wide backing store. Build option SD_BLOCK_WRITE_EN enables the write path;
// without it write requests are acked for a block time, flagged with err and
// never touch the store or the initiator buffer.
module sd_block_responder
    import sd_block_pkg::*;
#(
    parameter int VDNUM = 2,
    parameter int AW    = 24
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [VDNUM-1:0][31:0] sd_lba,
    input  logic [VDNUM-1:0]       sd_rd,
    input  logic [VDNUM-1:0]       sd_wr,
    output logic [VDNUM-1:0]       sd_ack,
    output logic [OFS_W-1:0]       sd_buff_addr,
    output logic [7:0]             sd_buff_dout,
    output logic                   sd_buff_wr,
    input  logic [VDNUM-1:0][7:0]  sd_buff_din,
    input  logic [VDNUM-1:0][31:0] img_blocks,
    output logic [AW-1:0]          mem_addr,
    output logic                   mem_rd,
    output logic                   mem_wr,
    output logic [7:0]             mem_din,
    input  logic [7:0]             mem_dout,
    input  logic                   mem_ready,
    output logic                   busy,
    output logic                   err
);

    localparam int IW = (VDNUM > 1) ? $clog2(VDNUM) : 1;
    localparam logic [OFS_W-1:0] OFS_LAST = OFS_W'(BLK_BYTES - 1);
`ifdef SD_BLOCK_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [IW-1:0]    drv_q, drv_d;
    logic             wr_q, wr_d;
    logic             bad_q, bad_d;
    logic [31:0]      lba_q, lba_d;
    logic [OFS_W-1:0] ofs_q, ofs_d;
    logic [7:0]       data_q, data_d;
    logic             gap_q, gap_d;
    logic             err_q, err_d;

    logic             arb_any;
    logic [IW-1:0]    arb_idx;
    logic             xfer;

    sd_rr_arbiter #(.N(VDNUM), .IW(IW)) u_arb (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .req_i   (sd_rd | sd_wr),
        .take_i  (state_q == IDLE),
        .any_o   (arb_any),
        .idx_o   (arb_idx)
    );

    // Next-state logic: grant, per-byte read/write sequencing, post-block gap.
    always_comb begin
        state_d = state_q;
        drv_d   = drv_q;
        wr_d    = wr_q;
        bad_d   = bad_q;
        lba_d   = lba_q;
        ofs_d   = ofs_q;
        data_d  = data_q;
        gap_d   = gap_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    drv_d   = arb_idx;
                    wr_d    = !sd_rd[arb_idx];  // read wins when both are high
                    lba_d   = sd_lba[arb_idx];
                    ofs_d   = '0;
                    bad_d   = (sd_lba[arb_idx] >= img_blocks[arb_idx]);
                    err_d   = bad_d || (wr_d && !WR_EN);
                    state_d = ACK;
                end
            end
            ACK: state_d = wr_q ? WR_ADDR : RD_MEM;
            RD_MEM: begin
                // Out-of-range blocks read back as zeros with no store access.
                if (bad_q) begin
                    data_d  = 8'h00;
                    state_d = RD_PUT;
                end else if (mem_ready) begin
                    data_d  = mem_dout;
                    state_d = RD_PUT;
                end
            end
            RD_PUT: begin
                if (ofs_q == OFS_LAST) begin
                    state_d = DONE;
                end else begin
                    ofs_d   = ofs_q + 1'b1;
                    state_d = RD_MEM;
                end
            end
`ifdef SD_BLOCK_WRITE_EN
            WR_ADDR: state_d = WR_CAP;
            WR_CAP: begin
                // Buffer data lags sd_buff_addr by one cycle.
                data_d  = sd_buff_din[drv_q];
                state_d = WR_MEM;
            end
            WR_MEM: begin
                if (bad_q || mem_ready) begin
                    if (ofs_q == OFS_LAST) begin
                        state_d = DONE;
                    end else begin
                        ofs_d   = ofs_q + 1'b1;
                        state_d = WR_ADDR;
                    end
                end
            end
`else
            WR_ADDR: begin
                // Writes are swallowed: just burn one cycle per byte.
                if (ofs_q == OFS_LAST) begin
                    state_d = DONE;
                end else begin
                    ofs_d = ofs_q + 1'b1;
                end
            end
`endif
            DONE: begin
                gap_d   = 1'b0;
                state_d = GAP;
            end
            GAP: begin
                if (gap_q) begin
                    state_d = IDLE;
                end else begin
                    gap_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any block in flight.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= IDLE;
            drv_q   <= '0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            lba_q   <= '0;
            ofs_q   <= '0;
            data_q  <= '0;
            gap_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drv_q   <= drv_d;
            wr_q    <= wr_d;
            bad_q   <= bad_d;
            lba_q   <= lba_d;
            ofs_q   <= ofs_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
        end
    end

    assign xfer = (state_q == ACK) || (state_q == RD_MEM) || (state_q == RD_PUT) ||
                  (state_q == WR_ADDR) || (state_q == WR_CAP) || (state_q == WR_MEM);

    assign busy         = (state_q != IDLE);
    assign err          = err_q;
    assign sd_ack       = xfer ? (VDNUM'(1) << drv_q) : '0;
    assign sd_buff_wr   = (state_q == RD_PUT);
    assign sd_buff_dout = data_q;
    assign mem_rd       = (state_q == RD_MEM) && !bad_q;
    assign mem_din      = data_q;
    assign mem_addr     = AW'({drv_q, lba_q, ofs_q});

`ifdef SD_BLOCK_WRITE_EN
    assign mem_wr       = (state_q == WR_MEM) && !bad_q;
    assign sd_buff_addr = ofs_q;
`else
    logic unused_din;
    assign unused_din   = ^sd_buff_din;
    assign mem_wr       = 1'b0;
    // Swallowed writes never walk the initiator buffer.
    assign sd_buff_addr = wr_q ? '0 : ofs_q;
`endif

endmodule

// File: tb/tb_sd_block_responder.sv
// Self-checking bench for sd_block_responder (default VDNUM=2, AW=24).
// Write-path expectations follow SD_BLOCK_WRITE_EN as built.
module tb_sd_block_responder;

    localparam int VDNUM = 2;
    localparam int AW    = 24;

    typedef logic [31:0] ent_t;  // {addr(24), data(8)}

    logic                   clk_sys = 1'b0;
    logic                   reset_n;
    logic [VDNUM-1:0][31:0] sd_lba, img_blocks;
    logic [VDNUM-1:0]       sd_rd, sd_wr, sd_ack;
    logic [8:0]             sd_buff_addr;
    logic [7:0]             sd_buff_dout;
    logic                   sd_buff_wr;
    logic [VDNUM-1:0][7:0]  sd_buff_din;
    logic [AW-1:0]          mem_addr;
    logic                   mem_rd, mem_wr, mem_ready, busy, err;
    logic [7:0]             mem_din, mem_dout;

    int compared = 0, mismatched = 0;
    int mem_wait = 0, wait_cnt = 0;
    int n_buffwr, n_memrd, n_memwr, n_err;
    int n_both = 0, n_ackmulti = 0;
    ent_t exp_q[$], obs_q[$];

    sd_block_responder #(.VDNUM(VDNUM), .AW(AW)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd),
        .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
        .sd_buff_din(sd_buff_din), .img_blocks(img_blocks), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_ready(mem_ready), .busy(busy), .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    // Store address: {drive(1 bit for 2 drives), lba, offset}, low AW bits kept.
    function automatic logic [AW-1:0] addr_model(input int d, input logic [31:0] lba, input int ofs);
        logic [41:0] full;
        full = {d[0], lba, ofs[8:0]};
        return full[AW-1:0];
    endfunction

    function automatic logic [7:0] din_pat(input int d, input logic [8:0] a);
        int v;
        v = int'(a) * 7 + d * 49 + 3;
        return v[7:0];
    endfunction

    function automatic ent_t rd_ent(input int ofs, input logic [7:0] data);
        logic [8:0] o;
        o = ofs[8:0];
        return {15'd0, o, data};
    endfunction

    // Initiator buffer: data appears one cycle after the address.
    always @(posedge clk_sys)
        for (int d = 0; d < VDNUM; d++) sd_buff_din[d] <= din_pat(d, sd_buff_addr);

    // Backing store: byte = addr[7:0], ready after mem_wait cycles of request.
    always @(posedge clk_sys) wait_cnt <= (mem_rd || mem_wr) ? wait_cnt + 1 : 0;
    assign mem_ready = (mem_rd || mem_wr) && (wait_cnt >= mem_wait);
    assign mem_dout  = mem_addr[7:0];

    // Output collector (no checking here).
    always @(negedge clk_sys) begin
        if (reset_n === 1'b1) begin
            if (sd_buff_wr) begin obs_q.push_back({15'd0, sd_buff_addr, sd_buff_dout}); n_buffwr++; end
            if (mem_rd) n_memrd++;
            if (mem_wr && mem_ready) begin obs_q.push_back({mem_addr, mem_din}); n_memwr++; end
            if (err) n_err++;
            if (mem_rd && mem_wr) n_both++;
            if (!$onehot0(sd_ack)) n_ackmulti++;
        end
    end

    task automatic clr();
        exp_q.delete(); obs_q.delete();
        n_buffwr = 0; n_memrd = 0; n_memwr = 0; n_err = 0;
    endtask

    task automatic wait_ack(input int d, input logic lvl, input int budget, output int cyc);
        cyc = 0;
        do begin @(negedge clk_sys); cyc++; end while (sd_ack[d] !== lvl && cyc < budget);
        if (sd_ack[d] !== lvl) cyc = -1;
    endtask

    task automatic wait_idle(input int budget, output int cyc);
        cyc = 0;
        do begin @(negedge clk_sys); cyc++; end while (busy !== 1'b0 && cyc < budget);
        if (busy !== 1'b0) cyc = -1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sd_rd = '0; sd_wr = '0; sd_lba = '0; img_blocks = '0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        compared++; if (sd_ack !== '0) begin mismatched++; $display("FAIL reset_ack got %b want 00", sd_ack); end
        compared++; if ({sd_buff_wr, sd_buff_addr, sd_buff_dout} !== '0) begin mismatched++;
            $display("FAIL reset_buff got wr=%b addr=%h dout=%h want 0", sd_buff_wr, sd_buff_addr, sd_buff_dout); end
        compared++; if ({mem_rd, mem_wr, mem_addr, mem_din} !== '0) begin mismatched++;
            $display("FAIL reset_mem got rd=%b wr=%b addr=%h din=%h want 0", mem_rd, mem_wr, mem_addr, mem_din); end
        compared++; if ({busy, err} !== 2'b00) begin mismatched++; $display("FAIL reset_busy_err got %b%b want 00", busy, err); end
        reset_n = 1'b1;
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_who[$];
        logic [1:0] want;
        int c;
        clr();
        img_blocks[0] = 100; img_blocks[1] = 100; sd_lba[0] = 7; sd_lba[1] = 9;
        exp_who.push_back(2'b01); exp_who.push_back(2'b10); exp_who.push_back(2'b01);
        @(negedge clk_sys); sd_rd = 2'b11;
        for (int k = 0; k < 3; k++) begin
            c = 0;
            do begin @(negedge clk_sys); c++; end while (sd_ack === '0 && c < 50);
            want = exp_who.pop_front();
            compared++; if (sd_ack !== want) begin mismatched++; $display("FAIL arb_order%0d got %b want %b", k, sd_ack, want); end
            if (k == 2) sd_rd = '0;
            c = 0;
            do begin @(negedge clk_sys); c++; end while (sd_ack !== '0 && c < 3000);
        end
        wait_idle(100, c);
        compared++; if (n_buffwr !== 3 * 512) begin mismatched++; $display("FAIL arb_bytes got %0d want %0d", n_buffwr, 3 * 512); end
    endtask

    task automatic test_read_basic();
        int c, hi, g;
        ent_t e, o;
        clr(); mem_wait = 0;
        img_blocks[0] = 100; sd_lba[0] = 5;
        for (int i = 0; i < 512; i++) exp_q.push_back(rd_ent(i, addr_model(0, 5, i) & 8'hFF));
        @(negedge clk_sys); sd_rd[0] = 1'b1;
        wait_ack(0, 1'b1, 10, c);
        sd_rd[0] = 1'b0;  // dropping the request mid-block must not cut it short
        wait_ack(0, 1'b0, 3000, hi);
        wait_idle(100, g);
        compared++; if (c !== 1) begin mismatched++; $display("FAIL rd_ack_latency got %0d want 1", c); end
        compared++; if (hi !== 1 + 2 * 512) begin mismatched++; $display("FAIL rd_ack_len got %0d want %0d", hi, 1 + 2 * 512); end
        compared++; if (c + hi + g !== 2 + 2 * 512 + 3) begin mismatched++;
            $display("FAIL rd_block_time got %0d want %0d", c + hi + g, 2 + 2 * 512 + 3); end
        compared++; if (obs_q.size() !== 512) begin mismatched++; $display("FAIL rd_count got %0d want 512", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            compared++; if (o !== e) begin mismatched++; $display("FAIL rd_byte got %h want %h", o, e); end
        end
        compared++; if (n_err !== 0) begin mismatched++; $display("FAIL rd_err got %0d want 0", n_err); end
    endtask

    task automatic test_stream();
        int c, hi, g;
        logic [AW-1:0] want;
        clr(); mem_wait = 0;
        img_blocks[0] = 100; sd_lba[0] = 20;
        @(negedge clk_sys); sd_rd[0] = 1'b1;
        for (int k = 0; k < 13; k++) begin
            wait_ack(0, 1'b1, 20, c);
            if (k > 0) begin
                compared++; if (c < 2 || c > 6) begin mismatched++; $display("FAIL stream_gap%0d got %0d want 2..6", k, c); end
            end
            sd_lba[0] = sd_lba[0] + 1;
            if (k == 12) sd_rd[0] = 1'b0;
            c = 0;
            do begin @(negedge clk_sys); c++; end while (mem_rd !== 1'b1 && c < 50);
            want = addr_model(0, 20 + k, 0);
            compared++; if (mem_addr !== want) begin mismatched++; $display("FAIL stream_lba%0d got %h want %h", k, mem_addr, want); end
            wait_ack(0, 1'b0, 3000, hi);
        end
        wait_idle(100, g);
        repeat (10) @(negedge clk_sys);
        compared++; if (n_buffwr !== 13 * 512) begin mismatched++; $display("FAIL stream_bytes got %0d want %0d", n_buffwr, 13 * 512); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL stream_extra got busy=%b want 0", busy); end
    endtask

    task automatic test_write();
        int c, hi, g;
        ent_t e, o;
        clr(); mem_wait = 3;
        img_blocks[1] = 100; sd_lba[1] = 3;
`ifdef SD_BLOCK_WRITE_EN
        for (int i = 0; i < 512; i++) exp_q.push_back({addr_model(1, 3, i), din_pat(1, i[8:0])});
`endif
        @(negedge clk_sys); sd_wr[1] = 1'b1;
        wait_ack(1, 1'b1, 10, c);
        sd_wr[1] = 1'b0;
        wait_ack(1, 1'b0, 20000, hi);
        wait_idle(100, g);
        compared++; if (c !== 1) begin mismatched++; $display("FAIL wr_ack_latency got %0d want 1", c); end
        compared++; if (n_buffwr !== 0 || n_memrd !== 0) begin mismatched++;
            $display("FAIL wr_no_reads got strobes=%0d memrd=%0d want 0", n_buffwr, n_memrd); end
`ifdef SD_BLOCK_WRITE_EN
        compared++; if (obs_q.size() !== 512) begin mismatched++; $display("FAIL wr_count got %0d want 512", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            compared++; if (o !== e) begin mismatched++; $display("FAIL wr_byte got %h want %h", o, e); end
        end
        compared++; if (n_err !== 0) begin mismatched++; $display("FAIL wr_err got %0d want 0", n_err); end
`else
        compared++; if (n_memwr !== 0) begin mismatched++; $display("FAIL wr_off_memwr got %0d want 0", n_memwr); end
        compared++; if (n_err !== 1) begin mismatched++; $display("FAIL wr_off_err got %0d want 1", n_err); end
        compared++; if (hi < 512) begin mismatched++; $display("FAIL wr_off_ack_len got %0d want >=512", hi); end
`endif
        mem_wait = 0;
    endtask

    task automatic test_out_of_range();
        int c, hi, g;
        ent_t e, o;
        clr();
        img_blocks[0] = 100; sd_lba[0] = 200;
        for (int i = 0; i < 512; i++) exp_q.push_back(rd_ent(i, 8'h00));
        @(negedge clk_sys); sd_rd[0] = 1'b1;
        wait_ack(0, 1'b1, 10, c);
        sd_rd[0] = 1'b0;
        wait_ack(0, 1'b0, 3000, hi);
        wait_idle(100, g);
        compared++; if (obs_q.size() !== 512) begin mismatched++; $display("FAIL oor_count got %0d want 512", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            compared++; if (o !== e) begin mismatched++; $display("FAIL oor_byte got %h want %h", o, e); end
        end
        compared++; if (n_memrd !== 0) begin mismatched++; $display("FAIL oor_memrd got %0d want 0", n_memrd); end
        compared++; if (n_err !== 1) begin mismatched++; $display("FAIL oor_err got %0d want 1", n_err); end
    endtask

    task automatic test_reset_mid();
        int c, g;
        clr();
        img_blocks[0] = 100; sd_lba[0] = 1;
        @(negedge clk_sys); sd_rd[0] = 1'b1;
        c = 0;
        do begin @(negedge clk_sys); c++; end
        while (!(sd_buff_wr === 1'b1 && sd_buff_addr === 9'd300) && c < 2000);
        compared++; if (sd_buff_addr !== 9'd300) begin mismatched++; $display("FAIL mid_reach got %0d want 300", sd_buff_addr); end
        sd_rd[0] = 1'b0; reset_n = 1'b0;
        @(negedge clk_sys);
        compared++; if ({sd_ack, mem_rd, busy} !== '0) begin mismatched++;
            $display("FAIL mid_reset got ack=%b rd=%b busy=%b want 0", sd_ack, mem_rd, busy); end
        reset_n = 1'b1;
        clr();
        sd_rd[0] = 1'b1;
        c = 0;
        do begin @(negedge clk_sys); c++; end while (sd_buff_wr !== 1'b1 && c < 50);
        compared++; if (sd_buff_addr !== 9'd0 || sd_buff_wr !== 1'b1) begin mismatched++;
            $display("FAIL mid_restart got addr=%0d wr=%b want 0,1", sd_buff_addr, sd_buff_wr); end
        sd_rd[0] = 1'b0;
        wait_idle(3000, g);
    endtask

    task automatic test_invariants();
        compared++; if (n_both !== 0) begin mismatched++; $display("FAIL rd_wr_overlap got %0d want 0", n_both); end
        compared++; if (n_ackmulti !== 0) begin mismatched++; $display("FAIL ack_onehot got %0d want 0", n_ackmulti); end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_read_basic();
        test_stream();
        test_write();
        test_out_of_range();
        test_reset_mid();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
